// File: rtl/phase_accumulator.sv
// NCO phase generator: accumulates a frequency word, adds a phase offset and streams the truncated phase.
// Optional truncation dither is enabled by defining PHASE_ACC_DITHER_EN.
module phase_accumulator #(
  parameter int                PHASE_DW    = 16,
  parameter int                ACC_DW      = 32,
  parameter logic [ACC_DW-1:0] FREQ_INIT   = {ACC_DW{1'b0}},
  parameter logic [ACC_DW-1:0] OFFSET_INIT = {ACC_DW{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  sync_clear,
  input  logic [2*ACC_DW-1:0]   s_axis_cfg_tdata,
  input  logic                  s_axis_cfg_tvalid,
  output logic                  s_axis_cfg_tready,
  output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
  output logic                  m_axis_phase_tvalid,
  input  logic                  m_axis_phase_tready
);

  logic [ACC_DW-1:0]   acc_r;
  logic [ACC_DW-1:0]   freq_r;
  logic [ACC_DW-1:0]   offset_r;
  logic [PHASE_DW-1:0] tdata_r;
  logic                tvalid_r;
  logic                cfg_ready_r;

  logic                adv_s;
  logic                cfg_fire_s;
  logic [ACC_DW-1:0]   dither_s;
  logic [ACC_DW-1:0]   phase_sum_s;
  logic [PHASE_DW-1:0] phase_trunc_s;

  assign adv_s      = enable && (!tvalid_r || m_axis_phase_tready);
  assign cfg_fire_s = s_axis_cfg_tvalid && cfg_ready_r;

`ifdef PHASE_ACC_DITHER_EN
  localparam int DITH_W = ((ACC_DW - PHASE_DW) < 16) ? (ACC_DW - PHASE_DW) : 16;

  logic [15:0] lfsr_r;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  if (DITH_W > 0) begin : g_dither
    // Place the LFSR's top bits just below the retained phase bits
    always_comb begin
      dither_s = {ACC_DW{1'b0}};
      dither_s[ACC_DW-PHASE_DW-1 -: DITH_W] = lfsr_r[15 -: DITH_W];
    end
  end else begin : g_no_dither
    assign dither_s = {ACC_DW{1'b0}};
  end

  // Dither sequence advances once per produced sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= 16'hACE1;
    end else if (adv_s && !sync_clear) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end
`else
  assign dither_s = {ACC_DW{1'b0}};
`endif

  assign phase_sum_s   = acc_r + offset_r + dither_s;
  assign phase_trunc_s = PHASE_DW'(phase_sum_s >> (ACC_DW - PHASE_DW));

  // Output stage and accumulator; a stalled beat is never touched except by clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r    <= {ACC_DW{1'b0}};
      tdata_r  <= {PHASE_DW{1'b0}};
      tvalid_r <= 1'b0;
    end else if (sync_clear) begin
      acc_r    <= {ACC_DW{1'b0}};
      tvalid_r <= 1'b0;
    end else if (adv_s) begin
      tdata_r  <= phase_trunc_s;
      tvalid_r <= 1'b1;
      acc_r    <= acc_r + freq_r;
    end else if (!tvalid_r || m_axis_phase_tready) begin
      tvalid_r <= 1'b0;
    end
  end

  // Config port is always ready once out of reset; new values take effect from the next sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_r      <= FREQ_INIT;
      offset_r    <= OFFSET_INIT;
      cfg_ready_r <= 1'b0;
    end else begin
      cfg_ready_r <= 1'b1;
      if (cfg_fire_s) begin
        freq_r   <= s_axis_cfg_tdata[ACC_DW-1:0];
        offset_r <= s_axis_cfg_tdata[2*ACC_DW-1:ACC_DW];
      end
    end
  end

  assign s_axis_cfg_tready   = cfg_ready_r;
  assign m_axis_phase_tdata  = tdata_r;
  assign m_axis_phase_tvalid = tvalid_r;

endmodule
